// File: rtl/frame_minmax_tracker_if.sv
// Sample-in / frame-result-out handshake bundle for frame_minmax_tracker.
// The master drives samples and accepts results; the slave is the tracker.
interface frame_minmax_tracker_if #(
  parameter int N     = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_max;
  logic [N-1:0]     out_min;
  logic [CNT_W-1:0] out_count;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_min, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_min, out_count
  );
endinterface

// File: rtl/frame_minmax_tracker.sv
// Per-frame running max/min/count over a valid/ready sample stream; the result is
// held on the output side until handed off. Define MINMAX_SIGNED_EN for signed samples.
module frame_minmax_tracker #(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  frame_minmax_tracker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [N-1:0]     max_q, min_q;
  logic [CNT_W-1:0] count_q;
  logic [N-1:0]     out_max_q, out_min_q;
  logic [CNT_W-1:0] out_count_q;

  logic             accept_s;
  logic             handoff_s;
  logic [N-1:0]     max_d, min_d;
  logic [CNT_W-1:0] count_d;

  function automatic logic greater_than(input logic [N-1:0] a, input logic [N-1:0] b);
`ifdef MINMAX_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Candidate max/min/count if the sample on the bus is accepted this cycle
  always_comb begin
    accept_s  = bus.in_valid & in_ready_q;
    handoff_s = out_valid_q & bus.out_ready;
    max_d     = max_q;
    min_d     = min_q;
    count_d   = count_q;
    if (state_q == IDLE) begin
      max_d   = bus.in_data;
      min_d   = bus.in_data;
      count_d = CNT_W'(1);
    end else begin
      if (greater_than(bus.in_data, max_q)) begin
        max_d = bus.in_data;
      end else begin
        max_d = max_q;
      end
      if (greater_than(min_q, bus.in_data)) begin
        min_d = bus.in_data;
      end else begin
        min_d = min_q;
      end
      // Saturate instead of wrapping so long frames report the ceiling
      if (count_q == {CNT_W{1'b1}}) begin
        count_d = count_q;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Frame FSM with registered handshake flags and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      max_q       <= '0;
      min_q       <= '0;
      count_q     <= '0;
      out_max_q   <= '0;
      out_min_q   <= '0;
      out_count_q <= '0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept_s) begin
            max_q   <= max_d;
            min_q   <= min_d;
            count_q <= count_d;
            if (bus.in_last) begin
              state_q     <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
              out_max_q   <= max_d;
              out_min_q   <= min_d;
              out_count_q <= count_d;
            end else begin
              state_q    <= ACCUM;
              in_ready_q <= 1'b1;
            end
          end else begin
            // Also raises in_ready on the first cycle after reset release
            in_ready_q <= 1'b1;
          end
        end
        HOLD: begin
          if (handoff_s) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end else begin
            out_valid_q <= 1'b1;
            in_ready_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_max   = out_max_q;
  assign bus.out_min   = out_min_q;
  assign bus.out_count = out_count_q;

endmodule

// File: tb/tb_frame_minmax_tracker.sv
// Directed bench for frame_minmax_tracker: a CNT_W=16 instance for the main frames
// and a CNT_W=2 instance for counter saturation.
module tb_frame_minmax_tracker;

  logic clk;
  logic rst_n;
  int   checks_r;
  int   errors_r;

  frame_minmax_tracker_if #(.N(8), .CNT_W(16)) bus1 ();
  frame_minmax_tracker_if #(.N(8), .CNT_W(2))  bus2 ();

  frame_minmax_tracker #(.N(8), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  frame_minmax_tracker #(.N(8), .CNT_W(2))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present a sample, wait (bounded) for in_ready, return at the negedge after acceptance
  task automatic send1(input logic [7:0] d, input logic last);
    bus1.in_valid = 1'b1;
    bus1.in_data  = d;
    bus1.in_last  = last;
    for (int i = 0; i < 20 && !bus1.in_ready; i++) @(negedge clk);
    check_val("ready_wait1", {31'd0, bus1.in_ready}, 32'd1);
    @(negedge clk);
    bus1.in_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] d, input logic last);
    bus2.in_valid = 1'b1;
    bus2.in_data  = d;
    bus2.in_last  = last;
    for (int i = 0; i < 20 && !bus2.in_ready; i++) @(negedge clk);
    check_val("ready_wait2", {31'd0, bus2.in_ready}, 32'd1);
    @(negedge clk);
    bus2.in_valid = 1'b0;
  endtask

  task automatic check_result1(input string tag, input int mx, input int mn, input int cnt);
    check_val({tag, "_valid"}, {31'd0, bus1.out_valid}, 32'd1);
    check_val({tag, "_max"},   {24'd0, bus1.out_max},   mx);
    check_val({tag, "_min"},   {24'd0, bus1.out_min},   mn);
    check_val({tag, "_count"}, {16'd0, bus1.out_count}, cnt);
  endtask

  initial begin
    checks_r       = 0;
    errors_r       = 0;
    rst_n          = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_data   = 8'd0;
    bus1.in_last   = 1'b0;
    bus1.out_ready = 1'b1;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = 8'd0;
    bus2.in_last   = 1'b0;
    bus2.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    check_val("rst_in_ready",  {31'd0, bus1.in_ready},  32'd0);
    check_val("rst_out_valid", {31'd0, bus1.out_valid}, 32'd0);
    check_val("rst_max",       {24'd0, bus1.out_max},   32'd0);
    check_val("rst_count",     {16'd0, bus1.out_count}, 32'd0);
    rst_n = 1'b1;

    // Test 1: 5,200,17,200(last)
    send1(8'd5, 1'b0);
    send1(8'd200, 1'b0);
    send1(8'd17, 1'b0);
    send1(8'd200, 1'b1);
    check_result1("t1", 200, 5, 4);
    @(negedge clk);
    check_val("t1_valid_drop", {31'd0, bus1.out_valid}, 32'd0);
    check_val("t1_ready_back", {31'd0, bus1.in_ready},  32'd1);
    check_val("t1_max_kept",   {24'd0, bus1.out_max},   32'd200);

    // Test 2: single-sample frame
    send1(8'h42, 1'b1);
    check_result1("t2", 8'h42, 8'h42, 1);
    @(negedge clk);
    check_val("t2_ready_back", {31'd0, bus1.in_ready}, 32'd1);

    // Test 3: back-pressure on the result, then a new frame starting at 50
    bus1.out_ready = 1'b0;
    send1(8'd9, 1'b0);
    send1(8'd3, 1'b1);
    bus1.in_valid = 1'b1;
    bus1.in_data  = 8'd50;
    bus1.in_last  = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check_val("t3_in_ready", {31'd0, bus1.in_ready}, 32'd0);
      check_result1("t3_hold", 9, 3, 2);
      @(negedge clk);
    end
    bus1.out_ready = 1'b1;
    @(negedge clk);
    check_val("t3_valid_drop", {31'd0, bus1.out_valid}, 32'd0);
    check_val("t3_ready_back", {31'd0, bus1.in_ready},  32'd1);
    @(negedge clk);
    send1(8'd20, 1'b1);
    check_result1("t3_new", 50, 20, 2);

    // Descending/equal values exercise min updates and ties
    send1(8'd30, 1'b0);
    send1(8'd10, 1'b0);
    send1(8'd40, 1'b0);
    send1(8'd10, 1'b1);
    check_result1("mix", 40, 10, 4);

    // Test 4: CNT_W=2 saturation
    send2(8'd1, 1'b0);
    send2(8'd2, 1'b0);
    send2(8'd3, 1'b0);
    send2(8'd4, 1'b0);
    send2(8'd5, 1'b1);
    check_val("t4_valid", {31'd0, bus2.out_valid}, 32'd1);
    check_val("t4_count", {30'd0, bus2.out_count}, 32'd3);
    check_val("t4_max",   {24'd0, bus2.out_max},   32'd5);
    check_val("t4_min",   {24'd0, bus2.out_min},   32'd1);

    // Test 5: sign-dependent ordering
    send1(8'h80, 1'b0);
    send1(8'h7F, 1'b1);
`ifdef MINMAX_SIGNED_EN
    check_result1("t5", 8'h7F, 8'h80, 2);
`else
    check_result1("t5", 8'h80, 8'h7F, 2);
`endif
    @(negedge clk);

    // Test 6: reset mid-frame discards the partial frame
    send1(8'd10, 1'b0);
    send1(8'd20, 1'b0);
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_ready", {31'd0, bus1.in_ready},  32'd0);
    check_val("t6_rst_valid", {31'd0, bus1.out_valid}, 32'd0);
    check_val("t6_rst_max",   {24'd0, bus1.out_max},   32'd0);
    check_val("t6_rst_min",   {24'd0, bus1.out_min},   32'd0);
    check_val("t6_rst_count", {16'd0, bus1.out_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send1(8'd7, 1'b1);
    check_result1("t6", 7, 7, 1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_r, errors_r);
    $finish;
  end

endmodule
